// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status-nibble constants and parser FSM state encoding
package midi_pkg;
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PBEND    = 4'hE;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_D1 = 2'd1, WAIT_D2 = 2'd2} state_t;
endpackage

// File: rtl/midi_parser.sv
// midi_parser: running-status MIDI byte parser emitting held note on/off events
module midi_parser
   import midi_pkg::*;
#(
   parameter bit CH_FILTER = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic [3:0] channel,
   output logic       ev_valid,
   output logic       ev_on,
   output logic [3:0] ev_chan,
   output logic [6:0] ev_note,
   output logic [6:0] ev_vel,
   input  logic       ev_ack,
   output logic       overrun,
   output logic [1:0] state
);
   state_t     state_q, state_d;
   logic [7:0] rs_q, rs_d;
   logic [6:0] d1_q, d1_d;
   logic       ev_valid_q, ev_valid_d, ev_on_q, ev_on_d, overrun_q, overrun_d;
   logic [3:0] ev_chan_q, ev_chan_d;
   logic [6:0] ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
   logic       is_data, is_sys, is_stat, short_msg, chan_ok, note_done, load;
   logic [3:0] rs_nib;

   assign is_data   = ~rx_data[7];
   assign is_sys    = rx_data[7:3] == 5'b11110;
   assign is_stat   = rx_data[7] & ~&rx_data[7:4];
   assign rs_nib    = rs_q[7:4];
   assign short_msg = rs_nib == PROG || rs_nib == CH_AT;
   assign chan_ok   = !CH_FILTER || rs_q[3:0] == channel;
   assign note_done = rx_ready && is_data && state_q == WAIT_D2 &&
                      (rs_nib == NOTE_OFF || rs_nib == NOTE_ON) && chan_ok;
   // an ack in the completion cycle frees the slot for the new event
   assign load      = note_done && (!ev_valid_q || ev_ack);

   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      d1_d    = d1_q;
      if (rx_ready) begin
         if (is_stat) begin
            rs_d    = rx_data;
            state_d = WAIT_D1;
         end else if (is_sys) begin
            rs_d    = '0;
            state_d = IDLE;
         end else if (is_data && state_q == WAIT_D1) begin
            d1_d    = rx_data[6:0];
            state_d = short_msg ? WAIT_D1 : WAIT_D2;
         end else if (is_data && state_q == WAIT_D2) begin
            state_d = WAIT_D1;
         end
      end
      ev_valid_d = load || (ev_valid_q && !ev_ack);
      ev_on_d    = load ? (rs_nib == NOTE_ON && rx_data[6:0] != 7'd0) : ev_on_q;
      ev_chan_d  = load ? rs_q[3:0] : ev_chan_q;
      ev_note_d  = load ? d1_q : ev_note_q;
      ev_vel_d   = load ? rx_data[6:0] : ev_vel_q;
      overrun_d  = note_done && ev_valid_q && !ev_ack;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rs_q       <= '0;
         d1_q       <= '0;
         ev_valid_q <= 1'b0;
         ev_on_q    <= 1'b0;
         ev_chan_q  <= '0;
         ev_note_q  <= '0;
         ev_vel_q   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         d1_q       <= d1_d;
         ev_valid_q <= ev_valid_d;
         ev_on_q    <= ev_on_d;
         ev_chan_q  <= ev_chan_d;
         ev_note_q  <= ev_note_d;
         ev_vel_q   <= ev_vel_d;
         overrun_q  <= overrun_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_on    = ev_on_q;
   assign ev_chan  = ev_chan_q;
   assign ev_note  = ev_note_q;
   assign ev_vel   = ev_vel_q;
   assign overrun  = overrun_q;
   assign state    = state_q;
endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed checks of a channel-filtered and an omni parser sharing one byte stream
module tb_midi_parser;
   logic       clk = 1'b0, reset = 1'b1, rx_ready = 1'b0, ev_ack = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [3:0] channel = 4'd0;
   logic       ev_valid, ev_on, overrun;
   logic [3:0] ev_chan;
   logic [6:0] ev_note, ev_vel;
   logic [1:0] state;
   logic       o_valid, o_on, o_overrun;
   logic [3:0] o_chan;
   logic [6:0] o_note, o_vel;
   logic [1:0] o_state;
   int n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   midi_parser #(.CH_FILTER(1'b1)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .channel(channel),
      .ev_valid(ev_valid), .ev_on(ev_on), .ev_chan(ev_chan), .ev_note(ev_note), .ev_vel(ev_vel),
      .ev_ack(ev_ack), .overrun(overrun), .state(state));

   midi_parser #(.CH_FILTER(1'b0)) dut_omni (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .channel(channel),
      .ev_valid(o_valid), .ev_on(o_on), .ev_chan(o_chan), .ev_note(o_note), .ev_vel(o_vel),
      .ev_ack(ev_ack), .overrun(o_overrun), .state(o_state));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic a = 1'b0);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      ev_ack   = a;
      @(negedge clk);
      rx_ready = 1'b0;
      ev_ack   = 1'b0;
   endtask

   task automatic ack();
      @(negedge clk);
      ev_ack = 1'b1;
      @(negedge clk);
      ev_ack = 1'b0;
   endtask

   task automatic check_ev(input string tag, input logic on, input logic [3:0] ch,
                           input logic [6:0] note, input logic [6:0] vel);
      check({tag, "_valid"}, ev_valid, 1);
      check({tag, "_on"}, ev_on, on);
      check({tag, "_chan"}, ev_chan, ch);
      check({tag, "_note"}, ev_note, note);
      check({tag, "_vel"}, ev_vel, vel);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;

      send(8'h90); send(8'h3C);
      check("lat_pre_valid", ev_valid, 0);
      check("lat_pre_state", state, 2);
      send(8'h64);
      check_ev("basic", 1, 0, 7'h3C, 7'h64);
      check("basic_state", state, 1);
      ack();
      check("ack_clear", ev_valid, 0);

      send(8'h40); send(8'h7F);
      check_ev("rs_on", 1, 0, 7'h40, 7'h7F);
      ack();
      send(8'h40); send(8'h00);
      check_ev("rs_vel0", 0, 0, 7'h40, 7'h00);
      ack();

      send(8'h90); send(8'h3C); send(8'hF8);
      check("rt_state", state, 2);
      check("rt_valid", ev_valid, 0);
      send(8'h50);
      check_ev("rt", 1, 0, 7'h3C, 7'h50);
      ack();
      send(8'h90); send(8'h3C); send(8'hF0);
      check("sys_state", state, 0);
      send(8'h40);
      check("sys_valid", ev_valid, 0);
      check("sys_state2", state, 0);

      send(8'h95); send(8'h3C); send(8'h64);
      check("filt_valid", ev_valid, 0);
      check("omni_valid", o_valid, 1);
      check("omni_chan", o_chan, 5);
      check("omni_note", o_note, 7'h3C);
      ack();
      check("omni_ack", o_valid, 0);
      ack();
      check("ack_idle_valid", ev_valid, 0);

      send(8'h80); send(8'h30); send(8'h20);
      check_ev("noteoff", 0, 0, 7'h30, 7'h20);
      ack();

      send(8'h90); send(8'h3C); send(8'h64);
      check_ev("ovr_first", 1, 0, 7'h3C, 7'h64);
      send(8'h3E); send(8'h70);
      check("ovr_pulse", overrun, 1);
      check_ev("ovr_held", 1, 0, 7'h3C, 7'h64);
      @(negedge clk);
      check("ovr_one_clk", overrun, 0);
      send(8'h40); send(8'h41, 1'b1);
      check_ev("ack_load", 1, 0, 7'h40, 7'h41);
      check("ack_load_ovr", overrun, 0);
      ack();
      check("ack_load_clear", ev_valid, 0);

      send(8'hB0); send(8'h07); send(8'h64);
      check("cc_valid", ev_valid, 0);
      check("cc_state", state, 1);
      send(8'hC0); send(8'h05);
      check("prog_state", state, 1);
      check("prog_valid", ev_valid, 0);

      send(8'h90); send(8'h3C);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_state", state, 0);
      check("mid_rst_valid", ev_valid, 0);
      check("mid_rst_note", ev_note, 0);
      check("mid_rst_vel", ev_vel, 0);
      check("mid_rst_chan", ev_chan, 0);
      check("mid_rst_on", ev_on, 0);
      @(negedge clk);
      reset = 1'b0;
      send(8'h3C); send(8'h64);
      check("post_rst_valid", ev_valid, 0);
      check("post_rst_state", state, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 Parameter CH_FILTER, default 1; 1 = accept only channel messages whose channel equals `channel`, 0 = omni (all channels).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the UART receiver, valid when rx_ready=1.
REQ-005 rx_ready  input  1  one-clk pulse per received byte.
REQ-006 channel  input  4  MIDI channel select (0-15), sampled each clk.
REQ-007 ev_valid  output  1  note event pending, held until acknowledged.
REQ-008 ev_on  output  1  1 = note on, 0 = note off.
REQ-009 ev_chan  output  4  channel of pending event.
REQ-010 ev_note  output  7  note number.
REQ-011 ev_vel  output  7  velocity.
REQ-012 ev_ack  input  1  consumer accepts the pending event when ev_valid=1.
REQ-013 overrun  output  1  one-clk pulse when a completed event is dropped.
REQ-014 state  output  2  current FSM state (debug).

Function
REQ-015 Bytes are processed only in cycles where rx_ready=1; other cycles hold all parser state.
REQ-016 FSM states: IDLE (no running status), WAIT_D1 (expecting first data byte), WAIT_D2 (expecting second data byte).
REQ-017 Realtime bytes 0xF8-0xFF are ignored with no change to state, running status or captured data.
REQ-018 Channel status 0x80-0xEF: latch status as running status, -> WAIT_D1, discard any partial message.
REQ-019 System common 0xF0-0xF7: clear running status, -> IDLE; subsequent data bytes are discarded until the next channel status.
REQ-020 Data byte (bit7=0) in IDLE: discarded.
REQ-021 Data byte in WAIT_D1: capture as d1; if running status is 0xCn/0xDn the message completes (discarded) and the FSM stays in WAIT_D1; otherwise -> WAIT_D2.
REQ-022 Data byte in WAIT_D2: message completes, -> WAIT_D1 with running status retained.
REQ-023 Only completed 0x8n and 0x9n messages generate events; 0xAn, 0xBn and 0xEn are parsed and discarded.
REQ-024 0x9n with velocity 0 generates ev_on=0; 0x9n with nonzero velocity generates ev_on=1; 0x8n generates ev_on=0 with its velocity passed through.
REQ-025 When CH_FILTER=1 and n != channel, a completed message generates no event; running status is still tracked.
REQ-026 Latency: ev_valid rises on the clk after the rx_ready cycle of the final data byte.
REQ-027 ev_valid and the ev_* fields stay stable until a cycle with ev_ack=1; ev_valid falls on the next clk.
REQ-028 ev_ack while ev_valid=0 has no effect.
REQ-029 Event completes while ev_valid=1 and ev_ack=0: the new event is dropped, the held event is unchanged, and overrun pulses for one clk.
REQ-030 Event completes in the same cycle as ev_ack=1 with ev_valid=1: the new event is loaded and ev_valid stays 1; no overrun.

Reset
REQ-031 Reset (at any time, including mid-message) forces state=IDLE, running status cleared, d1=0, ev_valid=0, ev_on=0, ev_chan=0, ev_note=0, ev_vel=0, overrun=0.
REQ-032 The first byte after reset deassertion is processed normally; a data byte arriving in that cycle is discarded per REQ-020.

Structure
REQ-033 Package midi_pkg holds: status-nibble constants (NOTE_OFF=0x8, NOTE_ON=0x9, POLY_AT=0xA, CC=0xB, PROG=0xC, CH_AT=0xD, PBEND=0xE) and the FSM state encoding (IDLE=0, WAIT_D1=1, WAIT_D2=2).
REQ-034 Single flat module with no sub-modules; byte classification is combinational and all registers are in one clocked domain.

Verification
REQ-035 CH_FILTER=1, channel=0; bytes 0x90,0x3C,0x64 -> one event: on=1, chan=0, note=0x3C, vel=0x64, valid rising one clk after the third rx_ready.
REQ-036 Running status: 0x90,0x40,0x7F,0x40,0x00 (with ack between events) -> event on/0x40/0x7F, then event off/0x40/0x00.
REQ-037 0x90,0x3C,0xF8,0x50 -> 0xF8 ignored; event on/0x3C/0x50. Also 0x90,0x3C,0xF0,0x40 -> no event, state=IDLE.
REQ-038 channel=0, CH_FILTER=1; 0x95,0x3C,0x64 -> no event. Same bytes with CH_FILTER=0 -> event with chan=5.
REQ-039 Two complete note messages with ev_ack held 0 -> first event retained, overrun pulses once; repeat with ev_ack=1 in the completion cycle -> second event loaded, no overrun.
REQ-040 Assert reset after 0x90,0x3C -> state=IDLE, all outputs 0; then 0x3C,0x64 -> no event.
